// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors, line levels.
// Pure declarations, no logic.
// Imported by both the TX and RX paths so frame format stays consistent.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// Loadable LSB-first shift register with a count of bits already shifted out.
// ser_bit is the bit that the next shift will hand out; ser_done rises once
// DATA_WIDTH shifts have happened since the last load.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;

  // Load replaces the word and restarts the count; shift drops the LSB.
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load) begin
      shreg_d = data;
      idx_d   = '0;
    end else if (shift) begin
      shreg_d = shreg_q >> 1;
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  // Shift register and bit index state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign ser_bit  = shreg_q[0];
  assign ser_done = (idx_q == IDX_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// tx_out/busy are registered; the start bit appears the cycle after data_valid.
// Requests are ignored while busy; one idle cycle separates consecutive frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t             state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q,      tx_d;
  logic                  busy_q,    busy_d;

  logic ser_load;
  logic ser_shift;
  logic ser_bit;
  logic ser_done;
  logic bit_end;
  logic par_bit;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .shift    (ser_shift),
    .data     (p_data),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  // Parity over the captured word; odd parity is the complement of even.
  assign par_bit = (par_typ_q == PAR_EVEN) ? (^data_q) : (~^data_q);

  // Next state, bit timer and next line level. The line level is computed for
  // the state being entered so tx_out can come straight from a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d  = IDLE_LVL;
        cnt_d = '0;
        if (data_valid) begin
          data_d    = p_data;
          par_en_d  = par_en;
          par_typ_d = par_typ;
          ser_load  = 1'b1;
          state_d   = START;
          tx_d      = START_LVL;
        end
      end

      START: begin
        if (bit_end) begin
          // Hand the first data bit to the line as we enter DATA.
          cnt_d     = '0;
          state_d   = DATA;
          ser_shift = 1'b1;
          tx_d      = ser_bit;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (ser_done) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = STOP;
              tx_d    = IDLE_LVL;
            end
          end else begin
            ser_shift = 1'b1;
            tx_d      = ser_bit;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = IDLE_LVL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          tx_d    = IDLE_LVL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = IDLE_LVL;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, timer, captured request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      tx_q      <= IDLE_LVL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default-timing instance plus a CLKS_PER_BIT=1 instance.
// Line waveform compared cycle by cycle against a frame model built from the
// frame rules (start, LSB-first data, parity by counting ones, stop).
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] pd0, pd1;
  logic       dv0, dv1, pe0, pe1, pt0, pt1;
  logic       tx0, tx1, busy0, busy1;

  int checks = 0;
  int errors = 0;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .p_data(pd0), .data_valid(dv0),
    .par_en(pe0), .par_typ(pt0), .tx_out(tx0), .busy(busy0)
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .p_data(pd1), .data_valid(dv1),
    .par_en(pe1), .par_typ(pt1), .tx_out(tx1), .busy(busy1)
  );

  // Expected line level at cycle i of a frame (cycle 0 = first start-bit cycle).
  function automatic logic exp_bit(logic [7:0] d, logic pe, logic pt, int cpb, int i);
    int pos;
    int ones;
    pos  = i / cpb;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(d[k]);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (pe && pos == 9) return pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  task automatic drive(int which, logic [7:0] d, logic pe, logic pt, logic v);
    if (which == 1) begin
      pd1 = d; pe1 = pe; pt1 = pt; dv1 = v;
    end else begin
      pd0 = d; pe0 = pe; pt0 = pt; dv0 = v;
    end
  endtask

  // Watch the line for n cycles; it must stay idle-high and not busy.
  task automatic check_idle(string name, int which, int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 1) begin
        if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
      end else begin
        if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s: %0d non-idle cycles observed, required 0", name, bad);
    end
  endtask

  // Launch one frame with a one-cycle request, scramble the inputs afterwards,
  // then compare the whole waveform and the busy duration. inject_at >= 0
  // pulses a second request (0xFF) at that frame cycle.
  task automatic run_frame(string name, int which, logic [7:0] d, logic pe, logic pt,
                           int inject_at);
    int   cpb;
    int   len;
    int   bad_idx;
    logic bad_val;
    logic obs;
    int   busy_cnt;
    cpb      = (which == 1) ? 1 : 16;
    len      = cpb * (10 + int'(pe));
    bad_idx  = -1;
    bad_val  = 1'b0;
    busy_cnt = 0;
    @(negedge clk);
    drive(which, d, pe, pt, 1'b1);
    @(posedge clk);
    #1;
    drive(which, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      obs = (which == 1) ? tx1 : tx0;
      if (obs !== exp_bit(d, pe, pt, cpb, i) && bad_idx < 0) begin
        bad_idx = i;
        bad_val = obs;
      end
      if (((which == 1) ? busy1 : busy0) === 1'b1) busy_cnt++;
      if (i == inject_at)     drive(which, 8'hFF, 1'b0, 1'b0, 1'b1);
      if (i == inject_at + 1) drive(which, 8'hFF, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (bad_idx >= 0) begin
      errors++;
      $display("FAIL %s_line: cycle %0d tx_out=%b, required %b (data %h)", name, bad_idx,
               bad_val, exp_bit(d, pe, pt, cpb, bad_idx), d);
    end
    checks++;
    if (busy_cnt !== len) begin
      errors++;
      $display("FAIL %s_busy: busy cycles %0d, required %0d", name, busy_cnt, len);
    end
    check_idle({name, "_after"}, which, (inject_at >= 0) ? 40 : 3);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b/%b busy=%b/%b, required tx=1 busy=0",
               tx0, tx1, busy0, busy1);
    end
    rst = 1'b0;
    check_idle("reset_idle0", 0, 50);
    checks++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle1: tx=%b busy=%b, required tx=1 busy=0", tx1, busy1);
    end
  endtask

  task automatic test_no_parity;
    run_frame("a5_nopar", 0, 8'hA5, 1'b0, 1'b0, -1);
  endtask

  task automatic test_parity;
    run_frame("07_even", 0, 8'h07, 1'b1, 1'b0, -1);
    run_frame("07_odd",  0, 8'h07, 1'b1, 1'b1, -1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 5; n++)
      run_frame("rand16", 0, 8'($urandom), 1'($urandom), 1'($urandom), -1);
    for (int n = 0; n < 6; n++)
      run_frame("rand1", 1, 8'($urandom), 1'($urandom), 1'($urandom), -1);
  endtask

  task automatic test_busy_lockout;
    run_frame("lockout", 0, 8'h55, 1'b0, 1'b0, 70);
  endtask

  task automatic test_back_to_back;
    int bad;
    logic et, eb;
    bad = 0;
    @(negedge clk);
    drive(1, 8'h3C, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if ((i % 11) == 10) begin
        et = 1'b1; eb = 1'b0;
      end else begin
        et = exp_bit(8'h3C, 1'b0, 1'b0, 1, i % 11); eb = 1'b1;
      end
      if (tx1 !== et || busy1 !== eb) begin
        if (bad == 0)
          $display("FAIL b2b_stream: cycle %0d tx=%b busy=%b, required tx=%b busy=%b",
                   i, tx1, busy1, et, eb);
        bad++;
      end
      if (i == 43) drive(1, 8'h3C, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (bad !== 0) errors++;
    check_idle("b2b_stop", 1, 15);
  endtask

  task automatic test_mid_frame_reset;
    logic [7:0] d;
    d = 8'($urandom) | 8'h08;
    @(negedge clk);
    drive(0, d, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 8'h00, 1'b0, 1'b0, 1'b0);
    // Data bit 3 occupies frame cycles 64..79.
    for (int i = 0; i <= 70; i++) @(negedge clk);
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit3: tx=%b busy=%b, required tx=1 busy=1", tx0, busy0);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tx=%b busy=%b, required tx=1 busy=0", tx0, busy0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("post_reset", 0, 20);
    run_frame("81_after_rst", 0, 8'h81, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_busy_lockout();
    test_back_to_back();
    test_random();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
